// File: rtl/connections.sv
// Shared datapath/controller types for the 2-way L1 cache.
// Per-way bit vectors use bit 0 for way 0 and bit 1 for way 1.
package connections;

    typedef enum logic {
        cacheline   = 1'b0,
        bus_adaptor = 1'b1
    } datain_sel_t;

    typedef enum logic [1:0] {
        no_write  = 2'b00,
        cpu_write = 2'b01,
        write_all = 2'b10
    } write_en_sel_t;

    typedef enum logic {
        cpu        = 1'b0,
        write_dirt = 1'b1
    } pmem_sel_t;

    typedef struct packed {
        logic [1:0]    tag_ld;
        logic [1:0]    valid_ld;
        logic [1:0]    dirty_ld;
        logic          lru_ld;
        logic [1:0]    valid_in;
        logic [1:0]    dirty_in;
        logic          lru_in;
        datain_sel_t   write_sel1;
        datain_sel_t   write_sel2;
        write_en_sel_t write_en_sel1;
        write_en_sel_t write_en_sel2;
        pmem_sel_t     pmem_address;
        logic          output_sel;
    } ctrl_out;

    typedef struct packed {
        logic       cache_hit;
        logic       way_hit;
        logic       lru_out;
        logic [1:0] valid_out;
        logic [1:0] dirty_out;
    } dpath_out;

endpackage

// File: rtl/cache_control.sv
// Hit / write-back / fill sequencer for the 2-way L1 cache.
// Outputs are combinational from the state register and the current inputs.
module cache_control
    import connections::*;
(
    input  logic     clk,
    input  logic     rst,
    input  logic     mem_read,
    input  logic     mem_write,
    output logic     mem_resp,
    output logic     pmem_read,
    output logic     pmem_write,
    input  logic     pmem_resp,
    input  dpath_out dpath,
    output ctrl_out  ctrl
);

    typedef enum logic [1:0] {
        IDLE,
        WRITEBACK,
        FILL
    } state_t;

    state_t state_q, state_d;
    logic   victim_q, victim_d;
    logic   req;
    logic   miss_victim;

    function automatic logic [1:0] way_mask(input logic way);
        return way ? 2'b10 : 2'b01;
    endfunction

    // Empty ways are filled before anything is evicted.
    function automatic logic pick_victim(input dpath_out d);
        if (!d.valid_out[0]) return 1'b0;
        if (!d.valid_out[1]) return 1'b1;
        return d.lru_out;
    endfunction

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            victim_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            victim_q <= victim_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        victim_d    = victim_q;
        mem_resp    = 1'b0;
        pmem_read   = 1'b0;
        pmem_write  = 1'b0;
        req         = mem_read | mem_write;
        miss_victim = pick_victim(dpath);

        ctrl               = '0;
        ctrl.write_sel1    = cacheline;
        ctrl.write_sel2    = cacheline;
        ctrl.write_en_sel1 = no_write;
        ctrl.write_en_sel2 = no_write;
        ctrl.pmem_address  = cpu;
        ctrl.output_sel    = dpath.way_hit;

        unique case (state_q)
            IDLE: begin
                if (req && dpath.cache_hit) begin
                    mem_resp     = 1'b1;
                    ctrl.lru_ld  = 1'b1;
                    ctrl.lru_in  = ~dpath.way_hit;
                    // A simultaneous read+write is serviced as a write.
                    if (mem_write) begin
                        ctrl.dirty_ld = way_mask(dpath.way_hit);
                        ctrl.dirty_in = way_mask(dpath.way_hit);
                        if (dpath.way_hit) begin
                            ctrl.write_en_sel2 = cpu_write;
                            ctrl.write_sel2    = bus_adaptor;
                        end else begin
                            ctrl.write_en_sel1 = cpu_write;
                            ctrl.write_sel1    = bus_adaptor;
                        end
                    end
                end else if (req) begin
                    victim_d = miss_victim;
                    if (dpath.valid_out[miss_victim] && dpath.dirty_out[miss_victim])
                        state_d = WRITEBACK;
                    else
                        state_d = FILL;
                end
            end

            WRITEBACK: begin
                pmem_write        = 1'b1;
                ctrl.pmem_address = write_dirt;
                ctrl.output_sel   = victim_q;
                if (pmem_resp) state_d = FILL;
            end

            FILL: begin
                pmem_read = 1'b1;
                if (pmem_resp) begin
                    ctrl.tag_ld   = way_mask(victim_q);
                    ctrl.valid_ld = way_mask(victim_q);
                    ctrl.valid_in = way_mask(victim_q);
                    ctrl.dirty_ld = way_mask(victim_q);
                    if (victim_q) ctrl.write_en_sel2 = write_all;
                    else          ctrl.write_en_sel1 = write_all;
                    state_d = IDLE;
                end
            end

            default: state_d = IDLE;
        endcase
    end

endmodule

// File: tb/tb_cache_control.sv
// Randomised scoreboard bench for cache_control against a request-level model.
module tb_cache_control;
    import connections::*;

    logic     clk = 1'b0;
    logic     rst = 1'b1;
    logic     mem_read = 1'b0;
    logic     mem_write = 1'b0;
    logic     mem_resp;
    logic     pmem_read;
    logic     pmem_write;
    logic     pmem_resp = 1'b0;
    dpath_out dpath = '0;
    ctrl_out  ctrl;

    typedef struct {
        logic    resp;
        logic    pr;
        logic    pw;
        ctrl_out c;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_errors = 0;

    // Model of the outstanding miss: is one in flight, does it still owe a
    // write-back, and which way it will replace.
    bit m_busy = 1'b0;
    bit m_wb = 1'b0;
    bit m_victim = 1'b0;

    cache_control dut (
        .clk       (clk),
        .rst       (rst),
        .mem_read  (mem_read),
        .mem_write (mem_write),
        .mem_resp  (mem_resp),
        .pmem_read (pmem_read),
        .pmem_write(pmem_write),
        .pmem_resp (pmem_resp),
        .dpath     (dpath),
        .ctrl      (ctrl)
    );

    always #5 clk = ~clk;

    function automatic ctrl_out idle_ctrl(input bit wh);
        ctrl_out c;
        c               = '0;
        c.write_sel1    = cacheline;
        c.write_sel2    = cacheline;
        c.write_en_sel1 = no_write;
        c.write_en_sel2 = no_write;
        c.pmem_address  = cpu;
        c.output_sel    = wh;
        return c;
    endfunction

    task automatic drive_cycle(input bit rd, input bit wr, input bit hit, input bit wh,
                               input bit lru, input bit [1:0] vld, input bit [1:0] drt,
                               input bit presp, input bit rs);
        exp_t e;
        bit   v;
        @(posedge clk);
        #1;
        if (rs) begin rd = 1'b0; wr = 1'b0; end
        rst             = rs;
        mem_read        = rd;
        mem_write       = wr;
        pmem_resp       = presp;
        dpath.cache_hit = hit;
        dpath.way_hit   = wh;
        dpath.lru_out   = lru;
        dpath.valid_out = vld;
        dpath.dirty_out = drt;

        e.resp = 1'b0;
        e.pr   = 1'b0;
        e.pw   = 1'b0;
        e.c    = idle_ctrl(wh);
        if (rs) begin
            m_busy = 1'b0; m_wb = 1'b0; m_victim = 1'b0;
        end else if (!m_busy) begin
            if (rd || wr) begin
                if (hit) begin
                    e.resp     = 1'b1;
                    e.c.lru_ld = 1'b1;
                    e.c.lru_in = !wh;
                    if (wr) begin
                        e.c.dirty_ld[wh] = 1'b1;
                        e.c.dirty_in[wh] = 1'b1;
                        if (wh) begin e.c.write_en_sel2 = cpu_write; e.c.write_sel2 = bus_adaptor; end
                        else    begin e.c.write_en_sel1 = cpu_write; e.c.write_sel1 = bus_adaptor; end
                    end
                end else begin
                    if (vld[0] == 1'b0)      v = 1'b0;
                    else if (vld[1] == 1'b0) v = 1'b1;
                    else                     v = lru;
                    m_victim = v;
                    m_busy   = 1'b1;
                    m_wb     = vld[v] && drt[v];
                end
            end
        end else if (m_wb) begin
            e.pw             = 1'b1;
            e.c.pmem_address = write_dirt;
            e.c.output_sel   = m_victim;
            if (presp) m_wb = 1'b0;
        end else begin
            e.pr = 1'b1;
            if (presp) begin
                e.c.tag_ld[m_victim]   = 1'b1;
                e.c.valid_ld[m_victim] = 1'b1;
                e.c.valid_in[m_victim] = 1'b1;
                e.c.dirty_ld[m_victim] = 1'b1;
                if (m_victim) e.c.write_en_sel2 = write_all;
                else          e.c.write_en_sel1 = write_all;
                m_busy = 1'b0;
            end
        end
        exp_q.push_back(e);
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req_v);
        n_checks++;
        if (act !== req_v) begin
            n_errors++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, act, req_v);
        end
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check("mem_resp",   {31'd0, mem_resp},   {31'd0, e.resp});
            check("pmem_read",  {31'd0, pmem_read},  {31'd0, e.pr});
            check("pmem_write", {31'd0, pmem_write}, {31'd0, e.pw});
            check("ctrl",       {12'd0, ctrl},       {12'd0, e.c});
            check("pmem_excl",  {31'd0, pmem_read & pmem_write}, 32'd0);
        end
    end

    initial begin
        // Reset, then hits.
        drive_cycle(0, 0, 0, 1, 0, 2'b00, 2'b00, 0, 1);
        drive_cycle(1, 0, 1, 1, 0, 2'b11, 2'b00, 0, 0);
        drive_cycle(0, 1, 1, 0, 0, 2'b11, 2'b00, 0, 0);
        drive_cycle(1, 1, 1, 1, 1, 2'b11, 2'b00, 0, 0);
        // Clean miss into way 1, three fill cycles, then the re-check hit.
        drive_cycle(1, 0, 0, 0, 0, 2'b01, 2'b00, 0, 0);
        drive_cycle(1, 0, 0, 0, 0, 2'b01, 2'b00, 0, 0);
        drive_cycle(1, 0, 0, 0, 0, 2'b01, 2'b00, 0, 0);
        drive_cycle(1, 0, 0, 0, 0, 2'b01, 2'b00, 1, 0);
        drive_cycle(1, 0, 1, 1, 0, 2'b11, 2'b00, 0, 0);
        // Dirty miss, LRU picks way 1.
        drive_cycle(0, 1, 0, 0, 1, 2'b11, 2'b10, 0, 0);
        drive_cycle(0, 1, 0, 0, 1, 2'b11, 2'b10, 0, 0);
        drive_cycle(0, 1, 0, 0, 1, 2'b11, 2'b10, 1, 0);
        drive_cycle(0, 1, 0, 0, 1, 2'b11, 2'b10, 0, 0);
        drive_cycle(0, 1, 0, 0, 1, 2'b11, 2'b10, 1, 0);
        drive_cycle(0, 1, 1, 1, 1, 2'b11, 2'b10, 0, 0);
        // Reset one cycle into a fill.
        drive_cycle(1, 0, 0, 0, 0, 2'b10, 2'b00, 0, 0);
        drive_cycle(1, 0, 0, 0, 0, 2'b10, 2'b00, 0, 0);
        drive_cycle(1, 0, 0, 0, 0, 2'b10, 2'b00, 0, 1);
        drive_cycle(0, 0, 0, 0, 0, 2'b10, 2'b00, 0, 0);
        drive_cycle(1, 0, 1, 0, 0, 2'b11, 2'b00, 0, 0);
        // Stray pmem_resp while idle with no request.
        drive_cycle(0, 0, 1, 1, 1, 2'b11, 2'b11, 1, 0);
        drive_cycle(0, 0, 0, 0, 1, 2'b11, 2'b11, 1, 0);

        for (int i = 0; i < 800; i++) begin
            drive_cycle($urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1,
                        $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1,
                        $urandom_range(0, 1) == 1, 2'($urandom_range(0, 3)),
                        2'($urandom_range(0, 3)), $urandom_range(0, 2) == 0,
                        $urandom_range(0, 49) == 0);
        end

        repeat (3) @(negedge clk);
        n_checks++;
        if (exp_q.size() != 0) begin
            n_errors++;
            $display("FAIL drain: %0d expected responses left, 0 required", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/cache_control.md
# cache_control

Sequencing controller for the 2-way set-associative L1 cache. It observes CPU-side requests, datapath status (`dpath_out`) and physical-memory handshakes, and drives the datapath control bundle (`ctrl_out`) through the hit, write-back and fill sequences. It sits between the bus adaptor/CPU port and physical memory, alongside the cache datapath it configures.

## Interface
Parameters:
- none. Associativity is fixed at 2 ways, matching the 2-bit per-way fields of `ctrl_out`/`dpath_out`.

Ports:
- `clk`  in  1  sole clock; all state updates on the rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `mem_read`  in  1  CPU read request; held until `mem_resp`.
- `mem_write`  in  1  CPU write request; held until `mem_resp`.
- `mem_resp`  out  1  CPU request complete.
- `pmem_read`  out  1  line fill request to physical memory.
- `pmem_write`  out  1  line write-back request to physical memory.
- `pmem_resp`  in  1  physical memory transfer complete.
- `dpath`  in  `dpath_out`  fields `cache_hit`, `way_hit`, `lru_out`, `valid_out[1:0]`, `dirty_out[1:0]`.
- `ctrl`  out  `ctrl_out`  datapath load enables, selects and write enables.

## Operation
- FSM states: `IDLE` (hit check), `WRITEBACK`, `FILL`.
- Default `ctrl` in every state:
  - all `*_ld` = 0 and all `*_in` = 0
  - `write_sel1`/`write_sel2` = `cacheline`
  - `write_en_sel1`/`write_en_sel2` = `no_write`
  - `pmem_address` = `cpu`
  - `output_sel` = `way_hit`
- `req = mem_read | mem_write`. If both are high, the request is treated as a write.
- `IDLE`, `req` high, `cache_hit` high:
  - `mem_resp` = 1 combinationally.
  - `lru_ld` = 1, `lru_in` = `~way_hit`, so LRU names the way not just used.
  - On a write only: the hit way gets `write_en_sel` = `cpu_write`, `write_sel` = `bus_adaptor`, `dirty_ld` = 1, `dirty_in` = 1.
  - Remain in `IDLE`.
- `IDLE`, `req` high, miss:
  - Victim = way 0 if `!valid_out[0]`; else way 1 if `!valid_out[1]`; else `lru_out`. The victim is latched into register `victim`.
  - Next state: `WRITEBACK` if the victim is valid and dirty, else `FILL`.
  - `mem_resp` = 0.
- `WRITEBACK`:
  - Outputs: `pmem_write` = 1, `pmem_address` = `write_dirt`, `output_sel` = `victim`.
  - On `pmem_resp`, go to `FILL`.
- `FILL`:
  - Outputs: `pmem_read` = 1, `pmem_address` = `cpu`.
  - On `pmem_resp`, for the victim way: `write_en_sel` = `write_all`, `write_sel` = `cacheline`, `tag_ld` = 1, `valid_ld` = 1 with `valid_in` = 1, `dirty_ld` = 1 with `dirty_in` = 0. Then go to `IDLE`.
  - The re-check in `IDLE` then hits and completes the request, including applying a write.
- `pmem_resp` is ignored in `IDLE`.
- `req` dropping mid-miss is a protocol violation. The in-flight write-back/fill still completes and the FSM returns to `IDLE`.
- `pmem_read` and `pmem_write` are never high in the same cycle.

## Timing
- Reset (async, immediate): state = `IDLE`, `victim` = 0. `mem_resp`, `pmem_read` and `pmem_write` are 0, and `ctrl` holds the defaults (`output_sel` = `dpath.way_hit`).
- Hit latency: `mem_resp` in the same cycle `req` is presented.
- Clean miss: 1 `IDLE` cycle, then `FILL` for N cycles until `pmem_resp`, then 1 `IDLE` cycle with `mem_resp`. Total 2+N cycles.
- Dirty miss: adds `WRITEBACK` for M cycles until its `pmem_resp`. Total 2+M+N cycles.
- `pmem_*` requests are held constant until `pmem_resp`. `pmem_resp` for a single cycle is sufficient.
- `victim` is stable from the first miss cycle until the return to `IDLE`.
- `rst` asserted mid-`WRITEBACK`/`FILL`: the transfer is abandoned and `pmem_*` drop immediately. After deassertion the FSM sits in `IDLE`.

## Structure
- Enums `datain_sel_t`, `write_en_sel_t`, `pmem_sel_t` and structs `ctrl_out`, `dpath_out` come from the shared `connections` package and are not redefined.
- The FSM state enum stays local to `cache_control`.
- No sub-module: one registered state/victim process plus one combinational output/next-state process with defaults assigned first.

## Test plan
- Read hit: `mem_read`=1, `cache_hit`=1, `way_hit`=1 → same-cycle `mem_resp`=1, `lru_ld`=1, `lru_in`=0, no write enables.
- Write hit way 0: `mem_write`=1, `cache_hit`=1, `way_hit`=0 → `write_en_sel1`=`cpu_write`, `write_sel1`=`bus_adaptor`, `dirty_ld`=01, `dirty_in`=01, `lru_in`=1.
- Clean miss: `valid_out`=01 → victim 1. Then `FILL` with `pmem_read`=1 for 3 cycles; on `pmem_resp`, `tag_ld`=10, `valid_ld`=10, `write_en_sel2`=`write_all`. Next cycle forced hit → `mem_resp`.
- Dirty miss: `valid_out`=11, `dirty_out`=10, `lru_out`=1 → `WRITEBACK` with `pmem_address`=`write_dirt`, `output_sel`=1. On `pmem_resp` → `FILL`, then `IDLE`. `pmem_read`/`pmem_write` are never both 1.
- Reset mid-`FILL`: assert `rst` 1 cycle into `FILL` → `pmem_read`=0 immediately. After release, `IDLE` with `mem_resp`=0 until a new hit.
- Stray `pmem_resp`=1 in `IDLE` with no request → no state change, all `*_ld` = 0.
